// File: rtl/intersection_phase_scheduler_if.sv
// intersection_phase_scheduler_if: scheduler bus (requests, clearance acks, grants, status)
// slave  : scheduler side (takes tick/requests/acks, drives grants and status)
// master : environment side (drives tick/requests/acks, observes grants and status)
interface intersection_phase_scheduler_if;
  logic       tick_en;
  logic       req_side;
  logic       req_ped;
  logic       main_clear;
  logic       side_clear;
  logic       main_go;
  logic       side_go;
  logic       ped_walk;
  logic       all_red;
  logic [2:0] phase;
  logic       side_pend;
  logic       ped_pend;
  logic       fault;
  modport slave (
    input  tick_en, req_side, req_ped, main_clear, side_clear,
    output main_go, side_go, ped_walk, all_red, phase, side_pend, ped_pend, fault
  );
  modport master (
    output tick_en, req_side, req_ped, main_clear, side_clear,
    input  main_go, side_go, ped_walk, all_red, phase, side_pend, ped_pend, fault
  );
endinterface

// File: rtl/intersection_phase_scheduler.sv
// intersection_phase_scheduler: right-of-way scheduler for main/side approaches plus a pedestrian phase
// i_clk, i_rst : clock, synchronous active-high reset
// io_bus       : slave modport; tick_en/req_side/req_ped/main_clear/side_clear in,
//                main_go/side_go/ped_walk/all_red/phase/side_pend/ped_pend/fault out
// SCHED_CLR_TIMEOUT_EN : when defined, a missing clearance ack leads to a sticky FAULT state
module intersection_phase_scheduler #(
  parameter int TW          = 5,
  parameter int INIT_TIME   = 6,
  parameter int MIN_GREEN   = 9,
  parameter int SIDE_GREEN  = 9,
  parameter int ALL_RED     = 2,
  parameter int PED_TIME    = 6,
  parameter int CLR_TIMEOUT = 12
) (
  input logic i_clk,
  input logic i_rst,
  intersection_phase_scheduler_if.slave io_bus
);
`ifdef SCHED_CLR_TIMEOUT_EN
  localparam bit L_TO_EN = 1'b1;
`else
  localparam bit L_TO_EN = 1'b0;
`endif
  typedef enum logic [2:0] {
    S_INIT, S_MAIN, S_MAIN_CLR, S_ALLRED, S_SIDE, S_SIDE_CLR, S_PED, S_FAULT
  } state_t;
  state_t        r_state, w_next;
  logic [TW-1:0] r_timer;
  logic          r_last_side, r_side_pend, r_ped_pend;
  logic          w_timeout, w_to_allred;
  assign w_timeout   = L_TO_EN && r_timer >= TW'(CLR_TIMEOUT);
  assign w_to_allred = w_next == S_ALLRED && r_state != S_ALLRED;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INIT:     w_next = r_timer >= TW'(INIT_TIME) ? S_MAIN : S_INIT;
      S_MAIN:     w_next = (r_timer >= TW'(MIN_GREEN) && (r_side_pend || r_ped_pend)) ? S_MAIN_CLR : S_MAIN;
      S_MAIN_CLR: w_next = io_bus.main_clear ? S_ALLRED : w_timeout ? S_FAULT : S_MAIN_CLR;
      S_SIDE:     w_next = r_timer >= TW'(SIDE_GREEN) ? S_SIDE_CLR : S_SIDE;
      S_SIDE_CLR: w_next = io_bus.side_clear ? S_ALLRED : w_timeout ? S_FAULT : S_SIDE_CLR;
      S_ALLRED:   w_next = r_timer < TW'(ALL_RED) ? S_ALLRED :
                           r_ped_pend ? S_PED :
                           (!r_last_side && r_side_pend) ? S_SIDE : S_MAIN;
      S_PED:      w_next = r_timer >= TW'(PED_TIME) ? S_ALLRED : S_PED;
      default:    w_next = S_FAULT;
    endcase
  end
  // last only flips to SIDE after side clearance; main clearance and any PED exit both leave it at MAIN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_INIT;
      r_timer     <= '0;
      r_last_side <= 1'b0;
      r_side_pend <= 1'b0;
      r_ped_pend  <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_timer     <= w_next != r_state ? '0 : (io_bus.tick_en && r_timer != '1) ? r_timer + 1'b1 : r_timer;
      r_side_pend <= (w_next == S_SIDE && r_state != S_SIDE) ? 1'b0 : r_side_pend | io_bus.req_side;
      r_ped_pend  <= (w_next == S_PED && r_state != S_PED) ? 1'b0 : r_ped_pend | io_bus.req_ped;
      r_last_side <= w_to_allred ? r_state == S_SIDE_CLR : r_last_side;
    end
  end
  assign io_bus.main_go   = r_state == S_MAIN;
  assign io_bus.side_go   = r_state == S_SIDE;
  assign io_bus.ped_walk  = r_state == S_PED;
  assign io_bus.all_red   = r_state inside {S_INIT, S_ALLRED, S_PED, S_FAULT};
  assign io_bus.phase     = r_state;
  assign io_bus.side_pend = r_side_pend;
  assign io_bus.ped_pend  = r_ped_pend;
  assign io_bus.fault     = L_TO_EN && r_state == S_FAULT;
endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// tb_intersection_phase_scheduler: vector table, random stimulus vs. rule model, bounded start-up wait
module tb_intersection_phase_scheduler;
`ifdef SCHED_CLR_TIMEOUT_EN
  localparam bit TO = 1'b1;
`else
  localparam bit TO = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  intersection_phase_scheduler_if bus();
  intersection_phase_scheduler dut (.i_clk(clk), .i_rst(rst), .io_bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    bit r, tk, rs, rp, mc, sc;
    int n;
    logic [2:0] ph;
    bit sp, pp;
  } vec_t;
  vec_t tv[$];
  // reference: phase codes as ints, dwell[] is the tick count a phase must reach before it may leave
  int dwell[8] = '{6, 9, 0, 2, 9, 0, 6, 0};
  int m_ph, m_t, m_last, m_sp, m_pp;
  task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", name, a, e);
    end
  endtask
  task automatic model_step(input bit r, tk, rs, rp, mc, sc);
    int n;
    if (r) begin
      m_ph = 0; m_t = 0; m_last = 1; m_sp = 0; m_pp = 0;
      return;
    end
    n = m_ph;
    case (m_ph)
      0: if (m_t >= dwell[0]) n = 1;
      1: if (m_t >= dwell[1] && (m_sp || m_pp)) n = 2;
      2: if (mc) begin n = 3; m_last = 1; end else if (TO && m_t >= 12) n = 7;
      3: if (m_t >= dwell[3]) n = m_pp ? 6 : (m_last == 1 && m_sp) ? 4 : 1;
      4: if (m_t >= dwell[4]) n = 5;
      5: if (sc) begin n = 3; m_last = 4; end else if (TO && m_t >= 12) n = 7;
      6: if (m_t >= dwell[6]) begin n = 3; m_last = 1; end
      default: n = 7;
    endcase
    m_sp = (n == 4 && m_ph != 4) ? 0 : (m_sp | rs);
    m_pp = (n == 6 && m_ph != 6) ? 0 : (m_pp | rp);
    m_t  = (n != m_ph) ? 0 : tk ? ((m_t + 1 > 31) ? 31 : m_t + 1) : m_t;
    m_ph = n;
  endtask
  function automatic logic [9:0] model_out();
    logic [2:0] p;
    p = 3'(m_ph);
    return {m_ph == 1, m_ph == 4, m_ph == 6, m_ph == 0 || m_ph == 3 || m_ph == 6 || m_ph == 7,
            p, m_sp[0], m_pp[0], TO && m_ph == 7};
  endfunction
  task automatic step(input bit r, tk, rs, rp, mc, sc);
    rst = r; bus.tick_en = tk; bus.req_side = rs; bus.req_ped = rp;
    bus.main_clear = mc; bus.side_clear = sc;
    @(posedge clk);
    model_step(r, tk, rs, rp, mc, sc);
    #1;
    check("model", 32'({bus.main_go, bus.side_go, bus.ped_walk, bus.all_red, bus.phase,
                        bus.side_pend, bus.ped_pend, bus.fault}), 32'(model_out()));
  endtask
  task automatic add(input bit r, tk, rs, rp, mc, sc, input int n, input logic [2:0] ph, input bit sp, pp);
    vec_t v;
    v.r = r; v.tk = tk; v.rs = rs; v.rp = rp; v.mc = mc; v.sc = sc;
    v.n = n; v.ph = ph; v.sp = sp; v.pp = pp;
    tv.push_back(v);
  endtask
  initial begin
    int k;
    add(1,1,0,0,0,0,   2, 0, 0, 0);
    add(0,1,0,0,0,0,   6, 0, 0, 0);
    add(0,1,0,0,0,0,   1, 1, 0, 0);
    add(0,1,0,0,0,0, 100, 1, 0, 0);
    add(1,1,0,0,0,0,   1, 0, 0, 0);
    add(0,1,0,0,0,0,   7, 1, 0, 0);
    add(0,1,0,0,0,0,   3, 1, 0, 0);
    add(0,1,1,0,0,0,   1, 1, 1, 0);
    add(0,1,0,0,0,0,   5, 1, 1, 0);
    add(0,1,0,0,0,0,   1, 2, 1, 0);
    add(0,1,0,0,0,0,   4, 2, 1, 0);
    add(0,1,0,0,1,0,   1, 3, 1, 0);
    add(0,1,0,0,0,0,   2, 3, 1, 0);
    add(0,1,0,0,0,0,   1, 4, 0, 0);
    add(0,1,0,0,0,0,   9, 4, 0, 0);
    add(0,1,0,0,0,0,   1, 5, 0, 0);
    add(0,1,0,0,0,1,   1, 3, 0, 0);
    add(0,1,0,0,0,0,   3, 1, 0, 0);
    add(0,1,1,0,0,0,   1, 1, 1, 0);
    add(0,1,0,1,0,0,   1, 1, 1, 1);
    add(0,1,0,0,0,0,   7, 1, 1, 1);
    add(0,1,0,0,0,0,   1, 2, 1, 1);
    add(0,1,0,0,1,0,   1, 3, 1, 1);
    add(0,1,0,0,0,0,   2, 3, 1, 1);
    add(0,1,0,0,0,0,   1, 6, 1, 0);
    add(0,1,0,0,0,0,   6, 6, 1, 0);
    add(0,1,0,0,0,0,   1, 3, 1, 0);
    add(0,1,0,0,0,0,   2, 3, 1, 0);
    add(0,1,1,0,0,0,   1, 4, 0, 0);
    add(0,1,1,0,0,0,   2, 4, 1, 0);
    add(1,1,0,0,0,0,   1, 0, 0, 0);
    add(0,1,0,0,0,0,   7, 1, 0, 0);
    add(0,1,0,0,0,1,   3, 1, 0, 0);
    add(0,1,0,0,1,0,   2, 1, 0, 0);
    add(0,1,1,0,0,0,   1, 1, 1, 0);
    add(0,0,0,0,0,0,  20, 1, 1, 0);
    add(0,1,0,0,0,0,   3, 1, 1, 0);
    add(0,1,0,0,0,0,   1, 2, 1, 0);
`ifdef SCHED_CLR_TIMEOUT_EN
    add(0,1,0,0,0,0,  12, 2, 1, 0);
    add(0,1,0,0,0,0,   1, 7, 1, 0);
    add(0,1,0,0,1,0,   5, 7, 1, 0);
`else
    add(0,1,0,0,0,0,  30, 2, 1, 0);
    add(0,1,0,0,1,0,   1, 3, 1, 0);
`endif
    add(1,1,0,0,0,0,   1, 0, 0, 0);
    bus.tick_en = 1'b1; bus.req_side = 1'b0; bus.req_ped = 1'b0;
    bus.main_clear = 1'b0; bus.side_clear = 1'b0;
    for (int i = 0; i < tv.size(); i++) begin
      repeat (tv[i].n) step(tv[i].r, tv[i].tk, tv[i].rs, tv[i].rp, tv[i].mc, tv[i].sc);
      check($sformatf("vec%0d phase", i), 32'(bus.phase), 32'(tv[i].ph));
      check($sformatf("vec%0d pend", i), 32'({bus.side_pend, bus.ped_pend}), 32'({tv[i].sp, tv[i].pp}));
    end
    for (int i = 0; i < 4000; i++)
      step($urandom_range(299) == 0, $urandom_range(3) != 0, $urandom_range(19) == 0,
           $urandom_range(39) == 0, $urandom_range(3) == 0, $urandom_range(3) == 0);
    step(1, 1, 0, 0, 0, 0);
    k = 0;
    while (bus.phase != 3'd1 && k < 20) begin
      step(0, 1, 0, 0, 0, 0);
      k++;
    end
    check("init_wait cycles", 32'(k), 32'd7);
    check("init_wait main_go", 32'(bus.main_go), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
